// File: rtl/scroll_shift_register.sv
// ---------------------------------------------------------------------------
// scroll_shift_register
//   Universal shift register holding the segment image of NSYM display
//   symbols of SYM bits each (W = SYM*NSYM). Supports parallel load,
//   1-bit or one-symbol steps left/right, shift-with-fill or rotate, and a
//   timed auto-scroll engine that performs a programmed number of steps,
//   one every PRESC clock cycles, reporting busy/done.
//
// Ports
//   clk      clock, all state changes on the rising edge
//   clr_n    synchronous reset, active low
//   load     parallel load of d, highest priority, aborts an auto-scroll
//   d        parallel load data (W bits)
//   s        00 hold, 01 step right, 10 step left, 11 parallel load of d
//   rot      1 = rotate, 0 = shift with fill
//   gran     0 = 1-bit step, 1 = one-symbol (SYM-bit) step
//   ser_in   fill bit for 1-bit shifts
//   fill     fill symbol for symbol shifts
//   step_en  manual mode: one step per cycle using s/rot/gran
//   start    begin an auto-scroll of 'steps' steps
//   steps    number of auto-scroll steps
//   q        register contents
//   busy     auto-scroll in progress
//   done     one-cycle pulse when an auto-scroll completes
// ---------------------------------------------------------------------------
module scroll_shift_register #(
    parameter int SYM   = 7,
    parameter int NSYM  = 4,
    parameter int PRESC = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  load,
    input  logic [SYM*NSYM-1:0]   d,
    input  logic [1:0]            s,
    input  logic                  rot,
    input  logic                  gran,
    input  logic                  ser_in,
    input  logic [SYM-1:0]        fill,
    input  logic                  step_en,
    input  logic                  start,
    input  logic [CNT_W-1:0]      steps,
    output logic [SYM*NSYM-1:0]   q,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = SYM * NSYM;
    // Keep the prescaler at least one bit wide so PRESC=1 still elaborates.
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [W-1:0]       q_q;
    logic               busy_q;
    logic               done_q;
    logic [PW-1:0]      presc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         s_q;
    logic               rot_q;
    logic               gran_q;

    // One step of the image. Direction codes 00/11 leave the image unchanged,
    // which is how an auto-scroll started with those codes runs as holds.
    function automatic logic [W-1:0] step_fn(
        input logic [W-1:0]   cur,
        input logic [1:0]     dir,
        input logic           r,
        input logic           g,
        input logic [SYM-1:0] f,
        input logic           sb
    );
        logic [W-1:0] res;
        res = cur;
        case (dir)
            2'b10: begin
                if (g) res = r ? {cur[W-SYM-1:0], cur[W-1:W-SYM]} : {cur[W-SYM-1:0], f};
                else   res = r ? {cur[W-2:0], cur[W-1]}           : {cur[W-2:0], sb};
            end
            2'b01: begin
                if (g) res = r ? {cur[SYM-1:0], cur[W-1:SYM]}     : {f, cur[W-1:SYM]};
                else   res = r ? {cur[0], cur[W-1:1]}             : {sb, cur[W-1:1]};
            end
            default: res = cur;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            presc_q <= '0;
            cnt_q   <= '0;
            s_q     <= 2'b00;
            rot_q   <= 1'b0;
            gran_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                // Load wins in every state and silently aborts a scroll.
                q_q     <= d;
                state_q <= IDLE;
                busy_q  <= 1'b0;
                presc_q <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (steps != '0) begin
                                s_q     <= s;
                                rot_q   <= rot;
                                gran_q  <= gran;
                                cnt_q   <= steps;
                                presc_q <= '0;
                                busy_q  <= 1'b1;
                                state_q <= RUN;
                            end else begin
                                // Zero-length scroll completes immediately.
                                done_q <= 1'b1;
                            end
                        end else if (s == 2'b11) begin
                            q_q <= d;
                        end else if (step_en) begin
                            q_q <= step_fn(q_q, s, rot, gran, fill, ser_in);
                        end
                    end
                    RUN: begin
                        if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            // Direction is latched; fill/ser_in are taken live.
                            q_q     <= step_fn(q_q, s_q, rot_q, gran_q, fill, ser_in);
                            cnt_q   <= cnt_q - 1'b1;
                            if (cnt_q == CNT_W'(1)) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_scroll_shift_register.sv
module tb_scroll_shift_register;

    localparam int SYM   = 7;
    localparam int NSYM  = 4;
    localparam int PRESC = 4;
    localparam int CNT_W = 8;
    localparam int W     = SYM * NSYM;

    logic               clk = 1'b0;
    logic               clr_n;
    logic               load;
    logic [W-1:0]       d;
    logic [1:0]         s;
    logic               rot;
    logic               gran;
    logic               ser_in;
    logic [SYM-1:0]     fill;
    logic               step_en;
    logic               start;
    logic [CNT_W-1:0]   steps;
    logic [W-1:0]       q;
    logic               busy;
    logic               done;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] mq;   // reference image

    scroll_shift_register #(
        .SYM(SYM), .NSYM(NSYM), .PRESC(PRESC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .clr_n(clr_n), .load(load), .d(d), .s(s), .rot(rot),
        .gran(gran), .ser_in(ser_in), .fill(fill), .step_en(step_en),
        .start(start), .steps(steps), .q(q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference step: treats the image as an integer and uses shifts/masks.
    function automatic logic [W-1:0] mstep(input logic [W-1:0] cur, input logic [1:0] dir,
                                           input logic r, input logic g,
                                           input logic [SYM-1:0] f, input logic sb);
        logic [63:0] v, fb, mask, res, lowm;
        int n;
        n    = g ? SYM : 1;
        v    = 64'(cur);
        mask = (64'd1 << W) - 64'd1;
        lowm = (64'd1 << n) - 64'd1;
        fb   = g ? 64'(f) : 64'(sb);
        if (dir == 2'b10)
            res = ((v << n) & mask) | (r ? (v >> (W - n)) : fb);
        else if (dir == 2'b01)
            res = (v >> n) | ((r ? (v & lowm) : fb) << (W - n));
        else
            res = v;
        return res[W-1:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Auto-scroll of n steps with latched controls; optional noise on the
    // inputs that must be ignored (or sampled live) while busy.
    task automatic run_auto(input int n, input logic [1:0] dir, input logic r,
                            input logic g, input bit noise);
        s = dir; rot = r; gran = g; steps = CNT_W'(n);
        start = 1'b1; step_en = 1'b0;
        cyc();
        start = 1'b0;
        if (n == 0) begin
            check("zero_done", 64'(done), 64'd1);
            check("zero_busy", 64'(busy), 64'd0);
            check("zero_q", 64'(q), 64'(mq));
        end else begin
            check("auto_busy_start", 64'(busy), 64'd1);
            check("auto_done_start", 64'(done), 64'd0);
            for (int k = 1; k <= n * PRESC; k++) begin
                if (noise && k < n * PRESC) begin
                    s       = 2'($urandom_range(0, 3));
                    rot     = 1'($urandom);
                    gran    = 1'($urandom);
                    start   = 1'($urandom);
                    steps   = CNT_W'($urandom_range(1, 9));
                    step_en = 1'($urandom);
                    fill    = SYM'($urandom);
                    ser_in  = 1'($urandom);
                end else begin
                    s = 2'b00; start = 1'b0; step_en = 1'b0;
                end
                cyc();
                if (k % PRESC == 0) mq = mstep(mq, dir, r, g, fill, ser_in);
                check("auto_q", 64'(q), 64'(mq));
                check("auto_busy", 64'(busy), (k < n * PRESC) ? 64'd1 : 64'd0);
                check("auto_done", 64'(done), (k == n * PRESC) ? 64'd1 : 64'd0);
            end
        end
        s = 2'b00; start = 1'b0; step_en = 1'b0;
        cyc();
        check("after_done", 64'(done), 64'd0);
        check("after_busy", 64'(busy), 64'd0);
        check("after_q", 64'(q), 64'(mq));
    endtask

    initial begin
        // Reset wins over load.
        clr_n = 1'b0; load = 1'b1; d = '1; s = 2'b00; rot = 1'b0; gran = 1'b0;
        ser_in = 1'b0; fill = '0; step_en = 1'b0; start = 1'b0; steps = '0;
        cyc();
        mq = '0;
        check("rst_q", 64'(q), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        clr_n = 1'b1; load = 1'b0;
        cyc();
        check("idle_q", 64'(q), 64'd0);

        // Manual 1-bit left shifts.
        load = 1'b1; d = W'(1);
        cyc();
        load = 1'b0; mq = W'(1);
        check("load_q", 64'(q), 64'(mq));
        s = 2'b10; gran = 1'b0; rot = 1'b0; ser_in = 1'b0; step_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            mq = mstep(mq, s, rot, gran, fill, ser_in);
            check("man_left", 64'(q), 64'(mq));
        end
        check("man_left_8", 64'(q), 64'h8);
        step_en = 1'b0; s = 2'b00;

        // Symbol rotate right.
        load = 1'b1; d = 28'h1234567;
        cyc();
        load = 1'b0; mq = 28'h1234567;
        s = 2'b01; gran = 1'b1; rot = 1'b1; step_en = 1'b1;
        cyc();
        step_en = 1'b0; s = 2'b00;
        mq = mstep(mq, 2'b01, 1'b1, 1'b1, fill, ser_in);
        check("sym_rot", 64'(q), 64'(mq));
        check("sym_rot_const", 64'(q), 64'h0CE2468A);

        // Auto-scroll: 3 symbol left shifts with all-ones fill.
        fill = 7'h7F;
        run_auto(3, 2'b10, 1'b0, 1'b1, 1'b0);
        check("auto_low21", 64'(q & 28'h01FFFFF), 64'h1FFFFF);

        // Ignored inputs while busy, live fill sampling.
        run_auto(3, 2'b01, 1'b1, 1'b0, 1'b1);
        run_auto(2, 2'b11, 1'b0, 1'b0, 1'b1);
        run_auto(2, 2'b00, 1'b1, 1'b1, 1'b0);
        run_auto(0, 2'b10, 1'b0, 1'b1, 1'b0);

        // Load aborts an auto-scroll with no done pulse.
        s = 2'b10; rot = 1'b1; gran = 1'b1; steps = CNT_W'(5); start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k % PRESC == 0) mq = mstep(mq, 2'b10, 1'b1, 1'b1, fill, ser_in);
            check("abort_pre_q", 64'(q), 64'(mq));
        end
        load = 1'b1; d = 28'h0A5A5A5;
        cyc();
        load = 1'b0; s = 2'b00; mq = 28'h0A5A5A5;
        check("abort_q", 64'(q), 64'(mq));
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        for (int k = 0; k < 2 * PRESC; k++) begin
            cyc();
            check("abort_quiet_done", 64'(done), 64'd0);
            check("abort_quiet_q", 64'(q), 64'(mq));
        end

        // Randomized mix of operations.
        for (int it = 0; it < 30; it++) begin
            int mode;
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin
                    for (int c = 0; c < 3; c++) begin
                        s = 2'($urandom_range(0, 2)); rot = 1'($urandom);
                        gran = 1'($urandom); fill = SYM'($urandom);
                        ser_in = 1'($urandom); step_en = 1'($urandom);
                        cyc();
                        if (step_en && s != 2'b00) mq = mstep(mq, s, rot, gran, fill, ser_in);
                        check("rnd_manual", 64'(q), 64'(mq));
                    end
                    step_en = 1'b0; s = 2'b00;
                end
                1: begin
                    d = W'($urandom); s = 2'b11;
                    cyc();
                    s = 2'b00; mq = d;
                    check("rnd_s11", 64'(q), 64'(mq));
                end
                2: begin
                    load = 1'b1; d = W'($urandom); s = 2'($urandom);
                    start = 1'($urandom); steps = CNT_W'($urandom_range(1, 4));
                    cyc();
                    load = 1'b0; start = 1'b0; s = 2'b00; mq = d;
                    check("rnd_load", 64'(q), 64'(mq));
                    check("rnd_load_busy", 64'(busy), 64'd0);
                end
                default: begin
                    fill = SYM'($urandom); ser_in = 1'($urandom);
                    run_auto($urandom_range(0, 3), 2'($urandom), 1'($urandom),
                             1'($urandom), 1'b1);
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
